// File: rtl/ed_round_monitor.sv
// Bounds an error-distance evaluation round to ROUND samples, then captures the total and divides it serially to get the mean.
// Latency: res_valid rises ACC_W+1 edges after the final sample is accepted. Backpressure: result held until res_valid && res_ready.
module ed_round_monitor #(
    parameter int ROUND = 102400,
    parameter int CNT_W = 17,
    parameter int ACC_W = 148,
    parameter bit CONT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ACC_W-1:0] acc_in,
    output logic             sample_ready,
    output logic             ed_reset,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] total_o,
    output logic [ACC_W-1:0] mean_o,
    output logic             ovf_o
);
    localparam int BIT_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(ROUND - 1);
    localparam logic [ACC_W:0]   DIVISOR = (ACC_W + 1)'(ROUND);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, DIVIDE, REPORT} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [ACC_W-1:0] prev_q;
    logic             ovf_q;
    logic [ACC_W-1:0] total_q;
    logic [ACC_W-1:0] mean_q;
    logic [ACC_W-1:0] quot_q;
    logic [ACC_W-1:0] rem_q;
    logic [BIT_W-1:0] bit_q;
    logic             sample_ready_q;
    logic             ed_reset_q;
    logic             busy_q;
    logic             res_valid_q;

    logic [ACC_W:0]   rem_sh;
    logic [ACC_W:0]   diff;
    logic             ge;
    logic [ACC_W-1:0] rem_d;
    logic [ACC_W-1:0] quot_d;
    logic             wrap;

    // Restoring step: the borrow out of the trial subtraction decides the quotient bit.
    always_comb begin
        rem_sh = {rem_q, quot_q[ACC_W-1]};
        diff   = rem_sh - DIVISOR;
        ge     = ~diff[ACC_W];
        rem_d  = ge ? diff[ACC_W-1:0] : rem_sh[ACC_W-1:0];
        quot_d = {quot_q[ACC_W-2:0], ge};
        wrap   = (acc_in < prev_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            count_q        <= '0;
            prev_q         <= '0;
            ovf_q          <= 1'b0;
            total_q        <= '0;
            mean_q         <= '0;
            quot_q         <= '0;
            rem_q          <= '0;
            bit_q          <= '0;
            sample_ready_q <= 1'b0;
            ed_reset_q     <= 1'b0;
            busy_q         <= 1'b0;
            res_valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= CLEAR;
                        ed_reset_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                CLEAR: begin
                    ed_reset_q     <= 1'b0;
                    count_q        <= '0;
                    prev_q         <= '0;
                    ovf_q          <= 1'b0;
                    sample_ready_q <= 1'b1;
                    state_q        <= RUN;
                end
                RUN: begin
                    count_q <= count_q + 1'b1;
                    prev_q  <= acc_in;
                    if (wrap) ovf_q <= 1'b1;
                    if (count_q == LAST) begin
                        sample_ready_q <= 1'b0;
                        state_q        <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    total_q <= acc_in;
                    quot_q  <= acc_in;
                    rem_q   <= '0;
                    bit_q   <= BIT_W'(ACC_W - 1);
                    prev_q  <= acc_in;
                    if (wrap) ovf_q <= 1'b1;
                    state_q <= DIVIDE;
                end
                DIVIDE: begin
                    quot_q <= quot_d;
                    rem_q  <= rem_d;
                    bit_q  <= bit_q - 1'b1;
                    if (bit_q == '0) begin
                        mean_q      <= quot_d;
                        res_valid_q <= 1'b1;
                        state_q     <= REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (CONT) begin
                            ed_reset_q <= 1'b1;
                            state_q    <= CLEAR;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    busy_q         <= 1'b0;
                    sample_ready_q <= 1'b0;
                    ed_reset_q     <= 1'b0;
                    res_valid_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sample_ready = sample_ready_q;
    assign ed_reset     = ed_reset_q;
    assign busy         = busy_q;
    assign res_valid    = res_valid_q;
    assign total_o      = total_q;
    assign mean_o       = mean_q;
    assign ovf_o        = ovf_q;
endmodule

// File: tb/tb_ed_round_monitor.sv
// Directed bench for ed_round_monitor: one CONT=0 instance and one CONT=1 instance, each fed by a behavioural accumulator.
module tb_ed_round_monitor;
    typedef struct packed {
        logic [15:0] total;
        logic [15:0] mean;
        logic        ovf;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic        res_ready_a, res_ready_b;
    logic [15:0] acc_a, acc_b;
    logic        sample_ready_a, ed_reset_a, busy_a, res_valid_a, ovf_a;
    logic        sample_ready_b, ed_reset_b, busy_b, res_valid_b, ovf_b;
    logic [15:0] total_a, mean_a, total_b, mean_b;

    logic [15:0] dlt [4];
    logic [1:0]  ka;
    res_t        qa[$];
    res_t        qb[$];
    res_t        e;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          sr_a = 0, er_a = 0, last_sr_a = 0, sr_b = 0, er_b = 0;

    ed_round_monitor #(.ROUND(4), .CNT_W(3), .ACC_W(16), .CONT(1'b0)) u_a (
        .clk(clk), .reset(rst_n), .start(start_a), .acc_in(acc_a),
        .sample_ready(sample_ready_a), .ed_reset(ed_reset_a), .busy(busy_a),
        .res_valid(res_valid_a), .res_ready(res_ready_a),
        .total_o(total_a), .mean_o(mean_a), .ovf_o(ovf_a)
    );

    ed_round_monitor #(.ROUND(4), .CNT_W(3), .ACC_W(16), .CONT(1'b1)) u_b (
        .clk(clk), .reset(rst_n), .start(start_b), .acc_in(acc_b),
        .sample_ready(sample_ready_b), .ed_reset(ed_reset_b), .busy(busy_b),
        .res_valid(res_valid_b), .res_ready(res_ready_b),
        .total_o(total_b), .mean_o(mean_b), .ovf_o(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus-side accumulators: advance one sample per cycle while sample_ready is high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_a <= '0;
            ka    <= '0;
            acc_b <= '0;
        end else begin
            if (ed_reset_a) begin
                acc_a <= '0;
                ka    <= '0;
            end else if (sample_ready_a) begin
                acc_a <= acc_a + dlt[ka];
                ka    <= ka + 1'b1;
            end
            if (ed_reset_b)          acc_b <= '0;
            else if (sample_ready_b) acc_b <= acc_b + 16'd3;
        end
    end

    always @(negedge clk) begin
        if (sample_ready_a) begin
            sr_a      <= sr_a + 1;
            last_sr_a <= cyc;
        end
        if (ed_reset_a)     er_a <= er_a + 1;
        if (sample_ready_b) sr_b <= sr_b + 1;
        if (ed_reset_b)     er_b <= er_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic res_t expect_of(input logic [15:0] d0, d1, d2, d3);
        res_t        r;
        logic [15:0] s;
        logic [15:0] nxt;
        logic [15:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        s = '0;
        r.ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nxt = s + d[i];
            if (nxt < s) r.ovf = 1'b1;
            s = nxt;
        end
        r.total = s;
        r.mean  = s / 16'd4;
        return r;
    endfunction

    task automatic run_round_a(input logic [15:0] d0, d1, d2, d3, input int hold);
        int  sr0, er0, rise;
        bit  seen;
        dlt[0] = d0; dlt[1] = d1; dlt[2] = d2; dlt[3] = d3;
        qa.push_back(expect_of(d0, d1, d2, d3));
        sr0 = sr_a;
        er0 = er_a;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        seen = 1'b0;
        rise = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (res_valid_a) begin
                seen = 1'b1;
                rise = cyc;
            end
        end
        chk("a_valid_seen", 32'(seen), 1);
        chk("a_sample_ready_cycles", 32'(sr_a - sr0), 4);
        chk("a_ed_reset_cycles", 32'(er_a - er0), 1);
        chk("a_latency", 32'(rise - last_sr_a), 18);
        chk("a_busy_report", 32'(busy_a), 1);
        repeat (hold) @(negedge clk);
        chk("a_valid_held", 32'(res_valid_a), 1);
        e = qa.pop_front();
        chk("a_total", 32'(total_a), 32'(e.total));
        chk("a_mean", 32'(mean_a), 32'(e.mean));
        chk("a_ovf", 32'(ovf_a), 32'(e.ovf));
        res_ready_a = 1'b1;
        @(negedge clk) res_ready_a = 1'b0;
        chk("a_valid_drop", 32'(res_valid_a), 0);
        chk("a_busy_idle", 32'(busy_a), 0);
        @(negedge clk);
        chk("a_stays_idle", 32'({busy_a, sample_ready_a, ed_reset_a}), 0);
        chk("a_total_kept", 32'(total_a), 32'(e.total));
    endtask

    task automatic wait_vld_b(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (res_valid_b) seen = 1'b1;
        end
        chk("b_valid_seen", 32'(seen), 1);
    endtask

    initial begin
        bit seen;
        int er0, sr0;
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        res_ready_a = 1'b0; res_ready_b = 1'b0;
        dlt[0] = '0; dlt[1] = '0; dlt[2] = '0; dlt[3] = '0;
        #3;
        chk("rst_ctrl", 32'({sample_ready_a, ed_reset_a, busy_a, res_valid_a, ovf_a}), 0);
        chk("rst_total", 32'(total_a), 0);
        chk("rst_mean", 32'(mean_a), 0);
        chk("rst_ctrl_b", 32'({sample_ready_b, ed_reset_b, busy_b, res_valid_b, ovf_b}), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // res_ready while nothing is pending must not start or disturb anything.
        res_ready_a = 1'b1;
        repeat (3) @(negedge clk);
        res_ready_a = 1'b0;
        chk("idle_ready_noeffect", 32'({busy_a, res_valid_a}), 0);

        run_round_a(16'd5, 16'd7, 16'd8, 16'd10, 10);
        run_round_a(16'd65530, 16'd9, 16'd0, 16'd0, 0);
        run_round_a(16'd1000, 16'd2000, 16'd3000, 16'd4001, 2);

        // Reset in the middle of DIVIDE clears everything without waiting for a clock edge.
        dlt[0] = 16'd100; dlt[1] = 16'd100; dlt[2] = 16'd100; dlt[3] = 16'd100;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int i = 0; i < 50 && !sample_ready_a; i++) @(negedge clk);
        for (int i = 0; i < 50 && sample_ready_a; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("mid_divide_busy", 32'({busy_a, res_valid_a}), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", 32'({sample_ready_a, ed_reset_a, busy_a, res_valid_a, ovf_a}), 0);
        chk("async_rst_total", 32'(total_a), 0);
        chk("async_rst_mean", 32'(mean_a), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run_round_a(16'd40000, 16'd20000, 16'd5000, 16'd535, 1);

        // Continuous mode: two rounds from a single start, with a stray start during RUN.
        qb.push_back(expect_of(16'd3, 16'd3, 16'd3, 16'd3));
        qb.push_back(expect_of(16'd3, 16'd3, 16'd3, 16'd3));
        er0 = er_b;
        sr0 = sr_b;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        wait_vld_b(seen);
        e = qb.pop_front();
        chk("b_total_r1", 32'(total_b), 32'(e.total));
        chk("b_mean_r1", 32'(mean_b), 32'(e.mean));
        chk("b_ed_reset_r1", 32'(er_b - er0), 1);
        chk("b_sample_ready_r1", 32'(sr_b - sr0), 4);
        res_ready_b = 1'b1;
        @(negedge clk) res_ready_b = 1'b0;
        chk("b_auto_clear", 32'({res_valid_b, ed_reset_b, busy_b}), 32'h3);
        wait_vld_b(seen);
        e = qb.pop_front();
        chk("b_total_r2", 32'(total_b), 32'(e.total));
        chk("b_mean_r2", 32'(mean_b), 32'(e.mean));
        chk("b_ovf_r2", 32'(ovf_b), 32'(e.ovf));
        chk("b_ed_reset_total", 32'(er_b - er0), 2);
        chk("b_sample_ready_total", 32'(sr_b - sr0), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
